// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: multi-lane MEM->WB pipeline register with WAW/r0 squash and commit counter.
// Latency: one cycle from inputs to outputs; no combinational input-to-output path.
// Backpressure: stall_i[0] holds all outputs, stall_i[1] inserts a bubble, flush_i bubbles over both.
module mem_wb_pipe #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter bit ZERO_SQUASH = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              stall_i,
  input  logic                    flush_i,
  input  logic                    cnt_clr_i,
  input  logic [LANES-1:0]        valid_i,
  input  logic [LANES-1:0]        we_i,
  input  logic [LANES*ADDR_W-1:0] waddr_i,
  input  logic [LANES*DATA_W-1:0] wdata_i,
  input  logic [LANES*PC_W-1:0]   pc_i,
  output logic [LANES-1:0]        valid_o,
  output logic [LANES-1:0]        we_o,
  output logic [LANES*ADDR_W-1:0] waddr_o,
  output logic [LANES*DATA_W-1:0] wdata_o,
  output logic [LANES*PC_W-1:0]   pc_o,
  output logic [CNT_W-1:0]        commit_cnt_o
);

  logic [LANES-1:0]        w_we_base;
  logic [LANES-1:0]        w_we_eff;
  logic [CNT_W-1:0]        w_pop;
  logic                    w_load;
  logic                    w_bubble;

  logic [LANES-1:0]        r_valid;
  logic [LANES-1:0]        r_we;
  logic [LANES*ADDR_W-1:0] r_waddr;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic [LANES*PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]        r_cnt;

  // Flush beats hold; hold beats an upstream bubble; otherwise load.
  assign w_bubble = flush_i | (~stall_i[0] & stall_i[1]);
  assign w_load   = ~flush_i & ~stall_i[0] & ~stall_i[1];

  // Per-lane write enable before conflict resolution: valid, enabled, and optionally not r0.
  always_comb begin
    w_we_base = '0;
    for (int i = 0; i < LANES; i++) begin
      w_we_base[i] = valid_i[i] & we_i[i];
      if (ZERO_SQUASH && (waddr_i[i*ADDR_W +: ADDR_W] == '0)) begin
        w_we_base[i] = 1'b0;
      end
    end
  end

  // A younger (higher-index) lane writing the same register kills the older lane's write.
  always_comb begin
    w_we_eff = w_we_base;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_we_base[j] && (waddr_i[j*ADDR_W +: ADDR_W] == waddr_i[i*ADDR_W +: ADDR_W])) begin
          w_we_eff[i] = 1'b0;
        end
      end
    end
  end

  // Number of valid lanes in the incoming bundle, zero-extended to the counter width.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + {{(CNT_W-1){1'b0}}, valid_i[i]};
    end
  end

  // Pipeline register: load, bubble, or hold; squashed lanes stay valid for commit tracing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_we    <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
    end else if (w_bubble) begin
      r_valid <= '0;
      r_we    <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
    end else if (w_load) begin
      r_valid <= valid_i;
      r_we    <= w_we_eff;
      r_waddr <= waddr_i;
      r_wdata <= wdata_i;
      r_pc    <= pc_i;
    end
  end

  // Commit counter: clear-then-add on a load edge, plain clear on any other edge, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= (cnt_clr_i ? '0 : r_cnt) + w_pop;
    end else if (cnt_clr_i) begin
      r_cnt <= '0;
    end
  end

  assign valid_o      = r_valid;
  assign we_o         = r_we;
  assign waddr_o      = r_waddr;
  assign wdata_o      = r_wdata;
  assign pc_o         = r_pc;
  assign commit_cnt_o = r_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed and randomized checks of mem_wb_pipe against a lane-level reference model.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit after it.
module tb_mem_wb_pipe;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [1:0]              stall_i = '0;
  logic                    flush_i = 1'b0;
  logic                    cnt_clr_i = 1'b0;
  logic [LANES-1:0]        valid_i = '0;
  logic [LANES-1:0]        we_i = '0;
  logic [LANES*ADDR_W-1:0] waddr_i = '0;
  logic [LANES*DATA_W-1:0] wdata_i = '0;
  logic [LANES*PC_W-1:0]   pc_i = '0;

  logic [LANES-1:0]        valid_o, we_o, valid_s, we_s;
  logic [LANES*ADDR_W-1:0] waddr_o, waddr_s;
  logic [LANES*DATA_W-1:0] wdata_o, wdata_s;
  logic [LANES*PC_W-1:0]   pc_o, pc_s;
  logic [31:0]             commit_cnt_o;
  logic [3:0]              commit_cnt_s;

  mem_wb_pipe dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
    .valid_i(valid_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .pc_i(pc_i),
    .valid_o(valid_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .pc_o(pc_o),
    .commit_cnt_o(commit_cnt_o)
  );

  mem_wb_pipe #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
    .valid_i(valid_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .pc_i(pc_i),
    .valid_o(valid_s), .we_o(we_s), .waddr_o(waddr_s), .wdata_o(wdata_s), .pc_o(pc_s),
    .commit_cnt_o(commit_cnt_s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one entry per lane.
  logic            m_valid [LANES];
  logic            m_we    [LANES];
  logic [ADDR_W-1:0] m_addr [LANES];
  logic [DATA_W-1:0] m_data [LANES];
  logic [PC_W-1:0]   m_pc   [LANES];
  logic [31:0]       m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] in_addr(input int i);
    return waddr_i[i*ADDR_W +: ADDR_W];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_valid[i] = 0; m_we[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_pc[i] = '0;
    end
    m_cnt = '0;
  endtask

  // Apply the edge rules to the model using the inputs present at this edge.
  task automatic model_edge();
    int pop;
    bit load;
    load = !flush_i && !stall_i[0] && !stall_i[1];
    pop = 0;
    for (int i = 0; i < LANES; i++) pop += int'(valid_i[i]);
    if (flush_i || (!stall_i[0] && stall_i[1])) begin
      for (int i = 0; i < LANES; i++) begin
        m_valid[i] = 0; m_we[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_pc[i] = '0;
      end
    end else if (load) begin
      for (int i = 0; i < LANES; i++) begin
        bit w;
        w = valid_i[i] && we_i[i] && (in_addr(i) != 0);
        for (int j = i + 1; j < LANES; j++)
          if (valid_i[j] && we_i[j] && in_addr(j) == in_addr(i)) w = 0;
        m_valid[i] = valid_i[i];
        m_we[i]    = w;
        m_addr[i]  = in_addr(i);
        m_data[i]  = wdata_i[i*DATA_W +: DATA_W];
        m_pc[i]    = pc_i[i*PC_W +: PC_W];
      end
    end
    if (load) m_cnt = (cnt_clr_i ? 32'd0 : m_cnt) + 32'(pop);
    else if (cnt_clr_i) m_cnt = '0;
  endtask

  task automatic check_all(input string tag);
    logic [LANES-1:0] ev, ew;
    logic [LANES*ADDR_W-1:0] ea;
    logic [LANES*DATA_W-1:0] ed;
    logic [LANES*PC_W-1:0] ep;
    for (int i = 0; i < LANES; i++) begin
      ev[i] = m_valid[i]; ew[i] = m_we[i];
      ea[i*ADDR_W +: ADDR_W] = m_addr[i];
      ed[i*DATA_W +: DATA_W] = m_data[i];
      ep[i*PC_W +: PC_W] = m_pc[i];
    end
    check({tag, ".valid"}, 64'(valid_o), 64'(ev));
    check({tag, ".we"},    64'(we_o),    64'(ew));
    check({tag, ".waddr"}, 64'(waddr_o), 64'(ea));
    check({tag, ".wdata"}, 64'(wdata_o), 64'(ed));
    check({tag, ".pc"},    64'(pc_o),    64'(ep));
    check({tag, ".cnt"},   64'(commit_cnt_o), 64'(m_cnt));
    check({tag, ".cnt4"},  64'(commit_cnt_s), 64'(m_cnt[3:0]));
    check({tag, ".we4"},   64'(we_s), 64'(ew));
  endtask

  // One clock: model follows the edge, outputs checked just after it, then next inputs may be driven.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] p0, input logic [31:0] p1);
    valid_i = v; we_i = w;
    waddr_i = {a1, a0}; wdata_i = {d1, d0}; pc_i = {p1, p0};
  endtask

  initial begin
    model_reset();
    // Reset asserted from time 0, released away from the edge.
    #12;
    check_all("reset0");
    rst = 1'b1;
    drive(2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 32'h10, 32'h14);
    cyc("load_a");
    cyc("load_b");
    // Asynchronous reset pulse between edges with nonzero inputs.
    #2; rst = 1'b0; #1;
    model_reset();
    check_all("async_rst");
    #1; rst = 1'b1;
    drive(2'b11, 2'b11, 5'd4, 5'd5, 32'hA, 32'hB, 32'h20, 32'h24);
    cyc("post_rst_load");
    check("post_rst_cnt", 64'(commit_cnt_o), 64'd2);

    // Load and latency: old values remain until the edge.
    drive(2'b11, 2'b11, 5'd3, 5'd7, 32'h1111_0000, 32'hDEAD_BEEF, 32'h100, 32'h104);
    #1; check_all("before_edge");
    cyc("lat_load");
    check("lat_we", 64'(we_o), 64'h3);
    check("lat_data1", 64'(wdata_o[63:32]), 64'hDEAD_BEEF);

    // WAW squash, r0 squash, invalid lane.
    drive(2'b11, 2'b11, 5'd9, 5'd9, 32'h5, 32'h6, 32'h200, 32'h204);
    cyc("waw");
    check("waw_we", 64'(we_o), 64'h2);
    check("waw_valid", 64'(valid_o), 64'h3);
    drive(2'b11, 2'b11, 5'd0, 5'd6, 32'h7, 32'h8, 32'h210, 32'h214);
    cyc("r0");
    check("r0_we0", 64'(we_o[0]), 64'h0);
    drive(2'b01, 2'b11, 5'd2, 5'd3, 32'h9, 32'hA, 32'h220, 32'h224);
    cyc("inv_lane");
    check("inv_we1", 64'(we_o[1]), 64'h0);

    // Hold for 3 cycles with changing inputs, then bubble, then resume.
    stall_i = 2'b01;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b11, 5'(k + 10), 5'(k + 20), $urandom, $urandom, $urandom, $urandom);
      cyc("hold");
    end
    stall_i = 2'b10;
    cyc("bubble");
    check("bubble_valid", 64'(valid_o), 64'h0);
    stall_i = 2'b00;
    cyc("resume");

    // Flush overrides hold.
    stall_i = 2'b01; flush_i = 1'b1;
    cyc("flush_hold");
    check("flush_valid", 64'(valid_o), 64'h0);
    stall_i = 2'b00; flush_i = 1'b0;

    // Counter wrap on the 4-bit instance.
    drive(2'b01, 2'b01, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 32'h4);
    for (int k = 0; k < 20 && m_cnt[3:0] != 4'd15; k++) cyc("preload");
    check("preload15", 64'(commit_cnt_s), 64'd15);
    drive(2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 32'h4);
    cyc("wrap");
    check("wrap_cnt4", 64'(commit_cnt_s), 64'd1);
    cnt_clr_i = 1'b1;
    drive(2'b10, 2'b10, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 32'h4);
    cyc("clr_load");
    check("clr_load_cnt", 64'(commit_cnt_o), 64'd1);
    stall_i = 2'b01;
    cyc("clr_stall");
    check("clr_stall_cnt", 64'(commit_cnt_o), 64'd0);
    cnt_clr_i = 1'b0; stall_i = 2'b00;

    // Randomized traffic with narrow addresses so conflicts and r0 writes are frequent.
    for (int k = 0; k < 400; k++) begin
      valid_i   = 2'($urandom);
      we_i      = 2'($urandom);
      waddr_i   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      wdata_i   = {$urandom, $urandom};
      pc_i      = {$urandom, $urandom};
      stall_i   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      flush_i   = ($urandom_range(0, 15) == 0);
      cnt_clr_i = ($urandom_range(0, 31) == 0);
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM→WB pipeline register, successor to the single-lane MEM/WB latch. Carries LANES independent write-back lanes (dual/quad-issue ready), each with a valid bit and PC for commit tracing. Supports hold, bubble and flush. Resolves same-bundle write-after-write conflicts and r0 writes before the regfile. Keeps a running count of committed instructions.

Parameters:
LANES, 2, number of write-back lanes (1..4)
DATA_W, 32, write data width
ADDR_W, 5, register address width
PC_W, 32, PC width per lane
CNT_W, 32, commit counter width
ZERO_SQUASH, 1, 1 = force we_o low for any lane whose waddr is 0

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
stall_i  in  2  [1] = MEM stage stopped, [0] = WB stage stopped (1 = Stop)
flush_i  in  1  exception/redirect flush
cnt_clr_i  in  1  synchronous clear of commit counter
valid_i  in  LANES  lane i carries an instruction
we_i  in  LANES  lane i write enable
waddr_i  in  LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]
wdata_i  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
pc_i  in  LANES*PC_W  lane i PC
valid_o  out  LANES  registered valid
we_o  out  LANES  registered, squashed write enable
waddr_o  out  LANES*ADDR_W  registered address
wdata_o  out  LANES*DATA_W  registered data
pc_o  out  LANES*PC_W  registered PC
commit_cnt_o  out  CNT_W  committed-instruction count

Behaviour:
- Reset (rst=0, async, independent of clk): all outputs 0, commit_cnt_o=0. Takes effect immediately, including mid-stall. First load possible on the first rising edge after rst returns to 1.
- Per-edge action, in priority order:
  1. flush_i=1: bubble (valid_o, we_o, waddr_o, wdata_o, pc_o all 0). Flush overrides hold.
  2. stall_i[0]=1: hold every output unchanged.
  3. stall_i[1]=1: bubble (upstream has nothing new).
  4. Otherwise: load.
- Load computes each lane's effective write enable e_i = valid_i[i] & we_i[i]:
  - ZERO_SQUASH=1 and waddr lane i = 0: e_i = 0.
  - WAW squash: if a higher-index lane j>i has e_j=1 and the same waddr, lane i gets e_i = 0. The highest index wins, matching program order.
  - we_o[i] = e_i. Data, addr, pc and valid are loaded unmodified; a squashed lane keeps valid_o=1 for tracing.
- Latency: one cycle input→output. No combinational input→output path.
- Commit counter: on a load edge, add popcount(valid_i).
  - Unchanged on hold, bubble and flush.
  - Wraps modulo 2^CNT_W.
  - cnt_clr_i=1 on a load edge: result = popcount(valid_i), i.e. clear then add.
  - cnt_clr_i=1 on any other edge: result = 0.
- Invalid lane (valid_i=0): we_o forced 0 regardless of we_i; lane not counted.
- LANES=1 degenerates to a single-lane register with no WAW logic.

Test Plan:
- Reset: drive inputs nonzero, pulse rst=0 between edges → all outputs and commit_cnt_o read 0 before the next edge. Release; one load with valid_i=2'b11 → commit_cnt_o=2.
- Load and latency: lane0 (addr 3, data 0x1111_0000, pc 0x100), lane1 (addr 7, data 0xDEAD_BEEF, pc 0x104), all valid/we, stall=00 → next cycle we_o=2'b11 with matching fields. Previous values visible until that edge.
- WAW and zero squash: both lanes addr 9 and we=1 → we_o=2'b10, valid_o=2'b11. Lane0 addr 0, we=1 → we_o[0]=0. Lane1 valid=0, we=1 → we_o[1]=0, count +1.
- Stall: stall=01 for 3 cycles with changing inputs → outputs frozen, count frozen. stall=10 → bubble: valid_o=0, we_o=0, waddr_o=0. stall=00 → resumes loading.
- Flush priority: stall=01 with flush_i=1 → outputs clear despite hold; count unchanged.
- Counter wrap/clear: CNT_W=4 with count preloaded to 15 via loads, load 2 valid lanes → 1. cnt_clr_i with a load of 1 lane → 1. cnt_clr_i during stall → 0.
